mw8080_vram_arbiter: RTL and testbench

- Shares the single-port 8 KB work/video RAM of the Midway 8080 core between three requesters: the ROM/RAM download loader, the video shifter fetch, and the 8080 CPU bus.
- Sits between the CPU core, the video timing logic and the synchronous RAM, replacing direct CPU-only RAM wiring.
- Makes one RAM access per clk_sys cycle, chosen by fixed priority with CPU anti-starvation.
- Reports video fetch deadline misses.

---
 rtl/mw8080_pkg.sv | 17 +
 rtl/mw8080_wait_ctr.sv | 51 +++++
 rtl/mw8080_vram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mw8080_vram_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw8080_pkg.sv
// Shared types and constants for the Midway 8080 work/video RAM arbiter.
package mw8080_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DL,
        GNT_VID,
        GNT_CPU
    } grant_t;

    localparam int RAM_AW = 13;
    localparam int RAM_DW = 8;
    localparam int WAIT_W = 4;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

endpackage

// File: rtl/mw8080_wait_ctr.sv
// Saturating age counter for one requester, with clear, freeze and a
// threshold output (level when count >= THRESH, or a one-shot on reaching it).
module mw8080_wait_ctr
    import mw8080_pkg::*;
#(
    parameter int THRESH = 4,
    parameter bit PULSE  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    input  logic freeze,
    output logic flag
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;
    logic [WAIT_W-1:0] thresh;

    assign thresh = WAIT_W'(THRESH);

    always_comb begin
        count_d = count_q;
        if (!freeze) begin
            if (gnt || !req) begin
                count_d = '0;
            end else if (count_q != WAIT_MAX) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // One-shot fires only on the transition into THRESH; saturation never re-arms it.
    always_comb begin
        if (PULSE) begin
            flag = (count_d == thresh) && (count_q != thresh);
        end else begin
            flag = (count_q >= thresh);
        end
    end

endmodule

// File: rtl/mw8080_vram_arbiter.sv
// One-access-per-cycle arbiter for the shared 8 KB RAM: loader, video fetch
// and CPU, with CPU anti-starvation and video deadline-miss reporting.
module mw8080_vram_arbiter
    import mw8080_pkg::*;
#(
    parameter int AW           = RAM_AW,
    parameter int DW           = RAM_DW,
    parameter int CPU_MAX_WAIT = 4,
    parameter int VID_DEADLINE = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_wdata,
    output logic          dl_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    output logic          vid_miss,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    grant_t        gnt;
    logic          cpu_starved;
    logic          vid_late;

    logic          dl_ack_q, dl_ack_d;
    logic          vid_ack_q, vid_ack_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          vid_miss_q, vid_miss_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    grant_t        rd_tag_q, rd_tag_d;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] vid_hold_q, vid_hold_d;
    logic [DW-1:0] cpu_hold_q, cpu_hold_d;

    mw8080_wait_ctr #(
        .THRESH (CPU_MAX_WAIT),
        .PULSE  (1'b0)
    ) u_cpu_wait (
        .clk    (clk_sys),
        .rst    (reset),
        .req    (cpu_req),
        .gnt    (gnt == GNT_CPU),
        .freeze (dl_active),
        .flag   (cpu_starved)
    );

    // The video deadline follows the beam, so it keeps aging during a download.
    mw8080_wait_ctr #(
        .THRESH (VID_DEADLINE),
        .PULSE  (1'b1)
    ) u_vid_wait (
        .clk    (clk_sys),
        .rst    (reset),
        .req    (vid_req),
        .gnt    (gnt == GNT_VID),
        .freeze (1'b0),
        .flag   (vid_late)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (dl_active) begin
            if (dl_req) gnt = GNT_DL;
        end else if (cpu_starved && cpu_req) begin
            gnt = GNT_CPU;
        end else if (vid_req) begin
            gnt = GNT_VID;
        end else if (cpu_req) begin
            gnt = GNT_CPU;
        end
    end

    always_comb begin
        dl_ack_d   = (gnt == GNT_DL);
        vid_ack_d  = (gnt == GNT_VID);
        cpu_ack_d  = (gnt == GNT_CPU);
        vid_miss_d = vid_late;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        rd_tag_d   = GNT_NONE;
        unique case (gnt)
            GNT_DL: begin
                ram_addr_d = dl_addr;
                ram_din_d  = dl_wdata;
                ram_we_d   = 1'b1;
            end
            GNT_VID: begin
                ram_addr_d = vid_addr;
                rd_tag_d   = GNT_VID;
            end
            GNT_CPU: begin
                ram_addr_d = cpu_addr;
                if (cpu_we) begin
                    ram_din_d = cpu_wdata;
                    ram_we_d  = 1'b1;
                end else begin
                    rd_tag_d  = GNT_CPU;
                end
            end
            GNT_NONE: begin
            end
        endcase
        vid_rvalid_d = (rd_tag_q == GNT_VID);
        cpu_rvalid_d = (rd_tag_q == GNT_CPU);
        vid_hold_d   = vid_rvalid_q ? ram_dout : vid_hold_q;
        cpu_hold_d   = cpu_rvalid_q ? ram_dout : cpu_hold_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_ack_q     <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_miss_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_din_q    <= '0;
            rd_tag_q     <= GNT_NONE;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vid_hold_q   <= '0;
            cpu_hold_q   <= '0;
        end else begin
            dl_ack_q     <= dl_ack_d;
            vid_ack_q    <= vid_ack_d;
            cpu_ack_q    <= cpu_ack_d;
            vid_miss_q   <= vid_miss_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_din_q    <= ram_din_d;
            rd_tag_q     <= rd_tag_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_hold_q   <= vid_hold_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    // Read data is live from the RAM in the valid cycle, then held.
    assign vid_rdata  = vid_rvalid_q ? ram_dout : vid_hold_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_dout : cpu_hold_q;
    assign dl_ack     = dl_ack_q;
    assign vid_ack    = vid_ack_q;
    assign cpu_ack    = cpu_ack_q;
    assign vid_miss   = vid_miss_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_mw8080_vram_arbiter.sv
// Directed plus randomized bench for mw8080_vram_arbiter against a
// cycle-level reference model of the arbitration rules and RAM contents.
module tb_mw8080_vram_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 8;
    localparam int CMW = 4;
    localparam int VD  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_active, dl_req, dl_ack;
    logic [AW-1:0] dl_addr;
    logic [DW-1:0] dl_wdata;
    logic          vid_req, vid_ack, vid_rvalid, vid_miss;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    mw8080_vram_arbiter #(
        .AW(AW), .DW(DW), .CPU_MAX_WAIT(CMW), .VID_DEADLINE(VD)
    ) dut (
        .clk_sys(clk), .reset(reset),
        .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr),
        .dl_wdata(dl_wdata), .dl_ack(dl_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid), .vid_miss(vid_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Synchronous single-port RAM, one cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_cpu_age, m_vid_age;
    int            pend_who;
    logic [DW-1:0] pend_data;
    logic          e_dl_ack, e_vid_ack, e_cpu_ack, e_miss, e_we;
    logic          e_vid_rv, e_cpu_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_vid_rd, e_cpu_rd;
    int            miss_seen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cpu_age = 0; m_vid_age = 0;
        pend_who = 0;  pend_data = '0;
        e_dl_ack = 0; e_vid_ack = 0; e_cpu_ack = 0; e_miss = 0; e_we = 0;
        e_vid_rv = 0; e_cpu_rv = 0;
        e_addr = '0; e_din = '0; e_vid_rd = '0; e_cpu_rd = '0;
    endtask

    // Apply the arbitration rules to the inputs of the current cycle.
    task automatic model_eval();
        int who;
        int old_vid;
        who = 0;
        if (dl_active) begin
            if (dl_req) who = 1;
        end else if (cpu_req && m_cpu_age >= CMW) who = 3;
        else if (vid_req) who = 2;
        else if (cpu_req) who = 3;
        if (!dl_active)
            m_cpu_age = (who == 3 || !cpu_req) ? 0
                        : (m_cpu_age < 15 ? m_cpu_age + 1 : 15);
        old_vid = m_vid_age;
        m_vid_age = (who == 2 || !vid_req) ? 0
                    : (m_vid_age < 15 ? m_vid_age + 1 : 15);
        e_miss = (m_vid_age == VD) && (old_vid != VD);
        e_dl_ack = (who == 1); e_vid_ack = (who == 2); e_cpu_ack = (who == 3);
        e_we = 0;
        if (who == 1) begin
            e_addr = dl_addr; e_din = dl_wdata; e_we = 1;
            ref_mem[dl_addr] = dl_wdata;
        end else if (who == 2) begin
            e_addr = vid_addr;
        end else if (who == 3) begin
            e_addr = cpu_addr;
            if (cpu_we) begin
                e_din = cpu_wdata; e_we = 1;
                ref_mem[cpu_addr] = cpu_wdata;
            end
        end
        e_vid_rv = (pend_who == 2);
        e_cpu_rv = (pend_who == 3);
        if (e_vid_rv) e_vid_rd = pend_data;
        if (e_cpu_rv) e_cpu_rd = pend_data;
        pend_who  = (who == 2 || (who == 3 && !cpu_we)) ? who : 0;
        pend_data = ref_mem[e_addr];
    endtask

    task automatic compare_all();
        chk("dl_ack", dl_ack, e_dl_ack);
        chk("vid_ack", vid_ack, e_vid_ack);
        chk("cpu_ack", cpu_ack, e_cpu_ack);
        chk("vid_miss", vid_miss, e_miss);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_we) chk("ram_din", ram_din, e_din);
        chk("vid_rvalid", vid_rvalid, e_vid_rv);
        chk("cpu_rvalid", cpu_rvalid, e_cpu_rv);
        chk("vid_rdata", vid_rdata, e_vid_rd);
        chk("cpu_rdata", cpu_rdata, e_cpu_rd);
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        compare_all();
        if (vid_miss) miss_seen++;
    endtask

    task automatic rand_update();
        if (cpu_req && cpu_ack) begin
            cpu_req = ($urandom % 2 == 0);
            cpu_we = $urandom % 2; cpu_addr = $urandom % 16;
            cpu_wdata = $urandom;
        end else if (cpu_req && $urandom % 16 == 0) begin
            cpu_req = 0;
        end else if (!cpu_req && $urandom % 3 == 0) begin
            cpu_req = 1; cpu_we = $urandom % 2;
            cpu_addr = $urandom % 16; cpu_wdata = $urandom;
        end
        if (vid_ack || (!vid_req && $urandom % 2 == 0)) begin
            vid_req = ($urandom % 4 != 0); vid_addr = $urandom % 16;
        end else if (vid_req && $urandom % 20 == 0) begin
            vid_req = 0;
        end
        if (dl_active) begin
            if ($urandom % 8 == 0) begin
                dl_active = 0; dl_req = ($urandom % 2 == 0);
            end else if (dl_ack || !dl_req) begin
                dl_req = ($urandom % 3 != 0);
                dl_addr = $urandom % 16; dl_wdata = $urandom;
            end
        end else begin
            dl_req = 0;
            if ($urandom % 25 == 0) dl_active = 1;
        end
    endtask

    initial begin
        int k, acks, first, miss0;
        int ack_at [$];
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0; ref_mem[i] = '0;
        end
        dl_active = 0; dl_req = 0; dl_addr = '0; dl_wdata = '0;
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        miss_seen = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 0;
        cycle();

        // CPU write, then read-back of the same location
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0400; cpu_wdata = 8'h5A;
        cycle();
        chk("t1_ack", cpu_ack, 1);
        chk("t1_we", ram_we, 1);
        chk("t1_addr", ram_addr, 13'h0400);
        chk("t1_din", ram_din, 8'h5A);
        cpu_req = 0;
        cycle();
        chk("t1_no_rvalid", cpu_rvalid, 0);
        cpu_req = 1; cpu_we = 0;
        cycle();
        chk("t2_ack", cpu_ack, 1);
        cpu_req = 0;
        cycle();
        chk("t2_rvalid", cpu_rvalid, 1);
        chk("t2_rdata", cpu_rdata, 8'h5A);
        chk("t2_vid_rv", vid_rvalid, 0);
        cycle();

        // Video hogging: CPU overrides on its fifth waiting cycle
        miss0 = miss_seen;
        vid_req = 1; vid_addr = 13'h0021;
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0400;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            cycle();
            if (cpu_ack) k = i;
        end
        chk("t3_cpu_turn", k, 5);
        cpu_req = 0;
        cycle();
        chk("t3_vid_back", vid_ack, 1);
        repeat (3) cycle();
        chk("t3_no_miss", miss_seen - miss0, 0);
        vid_req = 0;
        repeat (2) cycle();

        // Download burst with a waiting video request
        miss0 = miss_seen; first = 0;
        dl_active = 1; dl_req = 1; dl_addr = 13'h0000; dl_wdata = $urandom;
        vid_req = 1; vid_addr = 13'h0001;
        acks = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (dl_ack) begin
                acks++;
                dl_addr = dl_addr + 1'b1; dl_wdata = $urandom;
            end
            if (vid_miss && first == 0) first = i;
        end
        chk("t4_dl_acks", acks, 4);
        chk("t4_miss_at", first, 2);
        dl_active = 0; dl_req = 0;
        cycle();
        chk("t4_vid_after", vid_ack, 1);
        vid_req = 0;
        repeat (3) cycle();
        chk("t4_miss_once", miss_seen - miss0, 1);

        // Reset right after a CPU read is acknowledged
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0001;
        cycle();
        chk("t5_ack", cpu_ack, 1);
        cpu_req = 0;
        reset = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        chk("t5_no_rvalid", cpu_rvalid, 0);
        compare_all();
        reset = 0;
        cycle();

        // CPU gives up before being served while video is busy
        vid_req = 1; vid_addr = 13'h0002;
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1ABC; cpu_wdata = 8'hC3;
        acks = 0;
        repeat (3) begin
            cycle();
            if (cpu_ack) acks++;
        end
        cpu_req = 0;
        repeat (2) begin
            cycle();
            if (cpu_ack) acks++;
        end
        chk("t6_no_ack", acks, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0400;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            cycle();
            if (cpu_ack) k = i;
        end
        chk("t6_wait_cleared", k, 5);
        chk("t6_no_write", ref_mem[13'h1ABC], 8'h00);
        cpu_req = 0; vid_req = 0;
        repeat (3) cycle();

        // Random traffic from all three requesters
        ack_at.delete();
        for (int i = 0; i < 600; i++) begin
            cycle();
            if (dl_ack + vid_ack + cpu_ack > 1) ack_at.push_back(i);
            rand_update();
        end
        chk("rand_one_ack", ack_at.size(), 0);
        dl_active = 0; dl_req = 0; vid_req = 0; cpu_req = 0;
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
